serial_adder: RTL



---
 rtl/adder_defs_pkg.sv | 24 ++
 rtl/digit_adder.sv | 38 +++
 rtl/full_adder.sv | 18 +
 rtl/serial_adder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/adder_defs_pkg.sv
`default_nettype none
// ============================================================================
// adder_defs : shared FSM encoding and sizing helper for the serial adder
// Revision  : 1.0
// ============================================================================
package adder_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/digit_adder.sv
`default_nettype none
// ============================================================================
// digit_adder : DIGIT-bit ripple chain of full_adder cells
// Revision    : 1.0
// ============================================================================
module digit_adder #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             c_in,
   output logic [DIGIT-1:0] sum,
   output logic             c_out,
   output logic             c_msb
);

   logic [DIGIT:0] w_carry;

   assign w_carry[0] = c_in;

   generate
      for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
         full_adder u_fa (
            .a     (a[gi]),
            .b     (b[gi]),
            .c_in  (w_carry[gi]),
            .sum   (sum[gi]),
            .c_out (w_carry[gi+1])
         );
      end
   endgenerate

   // c_msb is the carry entering the top cell, needed for signed overflow
   assign c_out = w_carry[DIGIT];
   assign c_msb = w_carry[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// full_adder : single-bit full adder cell
// Revision   : 1.0
// ============================================================================
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// serial_adder : WIDTH-bit adder processing DIGIT bits per clock
// Revision     : 1.0
// ============================================================================
module serial_adder
   import adder_defs::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int             c_N    = WIDTH / DIGIT;
   localparam int             c_CW   = clog2(c_N) + 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

   state_t            r_state;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic              r_carry;
   logic [c_CW-1:0]   r_cnt;

   logic [DIGIT-1:0]  w_dsum;
   logic              w_dcout;
   logic              w_dcmsb;
   logic [WIDTH-1:0]  w_sum_next;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .a     (r_a[DIGIT-1:0]),
      .b     (r_b[DIGIT-1:0]),
      .c_in  (r_carry),
      .sum   (w_dsum),
      .c_out (w_dcout),
      .c_msb (w_dcmsb)
   );

   // Completed digits enter from the MSB end, so after N steps the
   // first digit has reached bit 0.
   generate
      if (DIGIT == WIDTH) begin : g_single_digit
         assign w_sum_next = w_dsum;
      end else begin : g_multi_digit
         logic [WIDTH-DIGIT-1:0] r_part;

         assign w_sum_next = {w_dsum, r_part};

         always_ff @(posedge clk) begin
            if (rst) begin
               r_part <= '0;
            end else if (r_state == RUN) begin
               r_part <= w_sum_next[WIDTH-1:DIGIT];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= c_in;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_a     <= r_a >> DIGIT;
               r_b     <= r_b >> DIGIT;
               r_carry <= w_dcout;
               r_cnt   <= r_cnt + c_CW'(1);
               if (r_cnt == c_LAST) begin
                  sum      <= w_sum_next;
                  c_out    <= w_dcout;
                  overflow <= w_dcmsb ^ w_dcout;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  r_state  <= DONE;
               end
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
